// File: rtl/verifier_field_unit_arbiter.sv
// Round-robin arbiter that lets nReq requesters share one external field-arithmetic unit.
// Operations are issued and results returned with the rising-edge en / ready handshake.
module verifier_field_unit_arbiter #(
  parameter int nReq    = 4,
  parameter int F_NBITS = 64
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic [nReq-1:0]    req_en,
  input  logic [F_NBITS-1:0] req_in [nReq-1:0][1:0],
  output logic [F_NBITS-1:0] req_out [nReq-1:0],
  output logic [nReq-1:0]    req_ready,
  output logic               unit_en,
  output logic [F_NBITS-1:0] unit_in [1:0],
  input  logic [F_NBITS-1:0] unit_out,
  input  logic               unit_ready,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  // Handshake: a 0->1 edge on an en starts one operation; the partner's ready
  // is low from that cycle until the result is valid. Operands stay stable
  // from the en rise until ready rises again, and the partner's ready is
  // meaningful only while it is not starting an operation.

  localparam int IW = (nReq > 1) ? $clog2(nReq) : 1;

  if (nReq < 2) begin : g_nreq_must_be_at_least_2
    $error("verifier_field_unit_arbiter: nReq must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t          state;
  logic [nReq-1:0] req_en_dly;
  logic [nReq-1:0] pending;
  logic [nReq-1:0] start;
  logic [nReq-1:0] grant_mask;
  logic [nReq-1:0] next_pending;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   grant_reg;
  logic            capture;
  logic            idle_found;
  logic [IW-1:0]   idle_idx;
  logic            wait_found;
  logic [IW-1:0]   wait_idx;

  // First set bit of mask scanning ptr+1, ptr+2, ... modulo nReq; MSB is "found".
  function automatic logic [IW:0] pick(input logic [nReq-1:0] mask,
                                       input logic [IW-1:0]   ptr);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= nReq; off++) begin
      cand = IW'((int'(ptr) + off) % nReq);
      if (!found && mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  assign start      = req_en & ~req_en_dly;
  assign req_ready  = ~pending & ~start;
  assign grant_mask = {{(nReq-1){1'b0}}, 1'b1} << grant_reg;
  assign capture    = (state == ST_WAIT) && unit_ready;

  // A start on an already-pending requester is absorbed by the OR; the
  // completing requester is cleared even if it pulses en during capture.
  assign next_pending = (pending | start) & ~(capture ? grant_mask : '0);

  assign {idle_found, idle_idx} = pick(pending, rr_ptr);
  assign {wait_found, wait_idx} = pick(pending & ~grant_mask, rr_ptr);

  assign unit_in[0] = req_in[grant_reg][0];
  assign unit_in[1] = req_in[grant_reg][1];
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      req_en_dly <= '1;
      pending    <= '0;
      for (int i = 0; i < nReq; i++) req_out[i] <= '0;
      rr_ptr     <= IW'(nReq - 1);
      grant_reg  <= '0;
      state      <= ST_IDLE;
      unit_en    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      req_en_dly <= req_en;
      pending    <= next_pending;
      unit_en    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (idle_found) begin
            grant_reg <= idle_idx;
            rr_ptr    <= idle_idx;
            state     <= ST_ISSUE;
            unit_en   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_ISSUE: begin
          // The unit drops ready combinationally here, so it is not sampled.
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (unit_ready) begin
            req_out[grant_reg] <= unit_out;
            if (wait_found) begin
              grant_reg <= wait_idx;
              rr_ptr    <= wait_idx;
              state     <= ST_ISSUE;
              unit_en   <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_verifier_field_unit_arbiter.sv
// Bench for verifier_field_unit_arbiter: field-adder stub (Lu = 3, p = 2^61-1),
// a cycle table, directed corner sequences, and random traffic against a reference model.
module tb_verifier_field_unit_arbiter;

  localparam int          N  = 4;
  localparam int          W  = 64;
  localparam int          LU = 3;
  localparam logic [63:0] P  = 64'h1FFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rstb;
  logic [N-1:0] req_en;
  logic [W-1:0] req_in [N-1:0][1:0];
  logic [W-1:0] req_out [N-1:0];
  logic [N-1:0] req_ready;
  logic         unit_en;
  logic [W-1:0] unit_in [1:0];
  logic [W-1:0] unit_out;
  logic         unit_ready;
  logic         busy;
  logic [1:0]   state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  verifier_field_unit_arbiter #(.nReq(N), .F_NBITS(W)) dut (
    .clk(clk), .rstb(rstb), .req_en(req_en), .req_in(req_in), .req_out(req_out),
    .req_ready(req_ready), .unit_en(unit_en), .unit_in(unit_in), .unit_out(unit_out),
    .unit_ready(unit_ready), .busy(busy), .state_dbg(state_dbg)
  );

  function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] s;
    s = a + b;
    if (s >= P) s = s - P;
    return s;
  endfunction

  function automatic logic [63:0] rnd_fe();
    logic [63:0] v;
    v = {$urandom(), $urandom()} & P;
    if (v == P) v = '0;
    return v;
  endfunction

  // Shared field-adder stub: result and ready Lu cycles after its en rise.
  logic       u_en_dly = 1'b0;
  logic [1:0] u_cnt    = 2'd0;
  logic [W-1:0] u_res  = '0;
  logic       u_start;
  assign u_start    = unit_en & ~u_en_dly;
  assign unit_ready = (u_cnt == 2'd0) && !u_start;
  assign unit_out   = u_res;
  always @(posedge clk) begin
    u_en_dly <= unit_en;
    if (u_start) begin
      u_cnt <= 2'(LU - 1);
      u_res <= fadd(unit_in[0], unit_in[1]);
    end else if (u_cnt != 2'd0) begin
      u_cnt <= u_cnt - 2'd1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: requests, grants and completions tracked as per-requester records.
  bit           active  [N];
  bit           granted [N];
  int           acc_cyc [N];
  logic [W-1:0] ops_a   [N];
  logic [W-1:0] ops_b   [N];
  logic [W-1:0] m_out   [N];
  logic [N-1:0] prev_en;
  int           last_grant;
  bit           inflight;
  int           inf_w;
  int           issue_cyc;
  int           n_issue = 0;
  logic [1:0]   exp_q[$];

  always @(negedge clk) begin : model
    int           w;
    int           act_g;
    int           k;
    bit           exp_en;
    logic [N-1:0] exp_ready;
    logic         edge_i;
    if (!rstb) begin
      chk("rst_ready", 64'(req_ready), 64'hF);
      chk("rst_unit_en", 64'(unit_en), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      for (int i = 0; i < N; i++) chk("rst_req_out", req_out[i], 64'd0);
      for (int i = 0; i < N; i++) begin
        active[i] = 0; granted[i] = 0; m_out[i] = '0; acc_cyc[i] = 0;
      end
      prev_en    = '1;
      last_grant = N - 1;
      inflight   = 0;
    end else begin
      if (inflight && cyc == issue_cyc + LU + 1) begin
        active[inf_w]  = 0;
        granted[inf_w] = 0;
        m_out[inf_w]   = fadd(ops_a[inf_w], ops_b[inf_w]);
        inflight       = 0;
      end
      w = -1;
      for (int off = 1; off <= N; off++) begin
        k = (last_grant + off) % N;
        if (w < 0 && active[k] && !granted[k] && acc_cyc[k] <= cyc - 2) w = k;
      end
      exp_en = !inflight && (w >= 0);
      chk("unit_en", 64'(unit_en), 64'(exp_en));
      if (unit_en && exp_en) begin
        act_g = -1;
        for (int i = 0; i < N; i++)
          if (act_g < 0 && active[i] && !granted[i] &&
              unit_in[0] == ops_a[i] && unit_in[1] == ops_b[i]) act_g = i;
        chk("grant", 64'(act_g), 64'(w));
        if (exp_q.size() > 0) chk("grant_order", 64'(act_g), 64'(exp_q.pop_front()));
        granted[w] = 1;
        last_grant = w;
        inflight   = 1;
        inf_w      = w;
        issue_cyc  = cyc;
        n_issue++;
      end
      chk("busy", 64'(busy), 64'(inflight));
      chk("busy_vs_state", 64'(busy), 64'(state_dbg != 2'd0));
      for (int i = 0; i < N; i++) begin
        edge_i       = req_en[i] & ~prev_en[i];
        exp_ready[i] = !active[i] && !edge_i;
        if (edge_i && !active[i]) begin
          active[i]  = 1;
          acc_cyc[i] = cyc;
          ops_a[i]   = req_in[i][0];
          ops_b[i]   = req_in[i][1];
        end
      end
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      for (int i = 0; i < N; i++) chk("req_out", req_out[i], m_out[i]);
      prev_en = req_en;
    end
  end

  typedef struct {
    logic        rstb;
    logic [3:0]  en;
    logic        exp_en;
    logic [3:0]  exp_ready;
    logic        exp_busy;
    logic [63:0] exp_out0;
  } vec_t;
  vec_t tbl [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      step();
      if (req_ready == '1 && !busy && !unit_en) break;
    end
    if (k == budget) begin
      n_vec++; n_err++;
      $display("FAIL wait_idle timeout cyc=%0d got=busy want=idle", cyc);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  lat;
    bit  hit;
    int  n0;
    //              rstb  en     uen   ready  busy  out0
    tbl[0]  = '{1'b0, 4'hF, 1'b0, 4'hF, 1'b0, 64'd0};
    tbl[1]  = '{1'b0, 4'hF, 1'b0, 4'hF, 1'b0, 64'd0};
    tbl[2]  = '{1'b1, 4'hF, 1'b0, 4'hF, 1'b0, 64'd0};
    tbl[3]  = '{1'b1, 4'hF, 1'b0, 4'hF, 1'b0, 64'd0};
    tbl[4]  = '{1'b1, 4'h0, 1'b0, 4'hF, 1'b0, 64'd0};
    tbl[5]  = '{1'b1, 4'h0, 1'b0, 4'hF, 1'b0, 64'd0};
    tbl[6]  = '{1'b1, 4'h1, 1'b0, 4'hE, 1'b0, 64'd0};
    tbl[7]  = '{1'b1, 4'h1, 1'b0, 4'hE, 1'b0, 64'd0};
    tbl[8]  = '{1'b1, 4'h0, 1'b1, 4'hE, 1'b1, 64'd0};
    tbl[9]  = '{1'b1, 4'h0, 1'b0, 4'hE, 1'b1, 64'd0};
    tbl[10] = '{1'b1, 4'h0, 1'b0, 4'hE, 1'b1, 64'd0};
    tbl[11] = '{1'b1, 4'h0, 1'b0, 4'hE, 1'b1, 64'd0};
    tbl[12] = '{1'b1, 4'h0, 1'b0, 4'hF, 1'b0, 64'd7};
    tbl[13] = '{1'b1, 4'h0, 1'b0, 4'hF, 1'b0, 64'd7};

    rstb   = 1'b1;
    req_en = '1;
    for (int i = 0; i < N; i++) begin
      req_in[i][0] = '0;
      req_in[i][1] = '0;
    end
    req_in[0][0] = 64'd3;
    req_in[0][1] = 64'd4;
    #2 rstb = 1'b0;

    // Reset with en held high, then a single request on requester 0.
    for (int r = 0; r < 14; r++) begin
      step();
      rstb   = tbl[r].rstb;
      req_en = tbl[r].en;
      @(negedge clk);
      chk("tbl_unit_en", 64'(unit_en), 64'(tbl[r].exp_en));
      chk("tbl_ready", 64'(req_ready), 64'(tbl[r].exp_ready));
      chk("tbl_busy", 64'(busy), 64'(tbl[r].exp_busy));
      chk("tbl_out0", req_out[0], tbl[r].exp_out0);
      chk("tbl_unit_in", {unit_in[1][31:0], unit_in[0][31:0]}, {32'd4, 32'd3});
    end

    // All four at once, twice: grants in order 0..3 both times.
    step(); rstb = 1'b0;
    step(); step(); rstb = 1'b1;
    step();
    for (int i = 0; i < N; i++) begin
      req_in[i][0] = 64'(i);
      req_in[i][1] = 64'd10;
    end
    for (int i = 0; i < N; i++) exp_q.push_back(2'(i));
    req_en = '1;
    step(); req_en = '0;
    wait_idle(40);
    for (int i = 0; i < N; i++) chk("burst1_out", req_out[i], 64'(10 + i));
    for (int i = 0; i < N; i++) begin
      req_in[i][0] = 64'(i);
      req_in[i][1] = 64'd20;
    end
    for (int i = 0; i < N; i++) exp_q.push_back(2'(i));
    step(); req_en = '1;
    step(); req_en = '0;
    wait_idle(40);
    for (int i = 0; i < N; i++) chk("burst2_out", req_out[i], 64'(20 + i));

    // Re-raise while pending is ignored.
    n0 = n_issue;
    req_in[1][0] = 64'd5;
    req_in[1][1] = 64'd6;
    req_en[1] = 1'b1; step();
    req_en[1] = 1'b0; step();
    req_en[1] = 1'b1; step();
    req_en[1] = 1'b0;
    wait_idle(20);
    chk("reraise_issues", 64'(n_issue - n0), 64'd1);
    chk("reraise_out", req_out[1], 64'd11);

    // Requester 2 re-issues in its ready-rise cycle while 3 is pending.
    exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd2);
    req_in[2][0] = 64'd7;
    req_in[2][1] = 64'd8;
    req_en[2] = 1'b1; step();
    req_en[2] = 1'b0; step();
    step();
    req_in[3][0] = 64'd9;
    req_in[3][1] = 64'd1;
    req_en[3] = 1'b1; step();
    req_en[3] = 1'b0;
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      step();
      if (req_ready[2]) begin
        req_in[2][0] = 64'd12;
        req_in[2][1] = 64'd13;
        req_en[2] = 1'b1;
        hit = 1;
      end
    end
    chk("reissue_seen", 64'(hit), 64'd1);
    step(); req_en[2] = 1'b0;
    wait_idle(30);
    chk("reissue_out2", req_out[2], 64'd25);
    chk("reissue_out3", req_out[3], 64'd10);
    chk("order_drained", 64'(exp_q.size()), 64'd0);

    // Reset during ST_WAIT, stale unit_ready ignored, then normal latency.
    req_in[0][0] = 64'd100;
    req_in[0][1] = 64'd200;
    req_en[0] = 1'b1; step();
    req_en[0] = 1'b0; step();
    step(); step();
    rstb = 1'b0;
    step(); step();
    rstb = 1'b1;
    chk("wait_rst_ready", 64'(req_ready), 64'hF);
    for (int i = 0; i < N; i++) chk("wait_rst_out", req_out[i], 64'd0);
    step(); step(); step();
    req_in[1][0] = 64'd30;
    req_in[1][1] = 64'd40;
    req_en[1] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      step();
      if (k == 1) req_en[1] = 1'b0;
      if (req_ready[1]) lat = k;
    end
    chk("post_rst_latency", 64'(lat), 64'(LU + 3));
    chk("post_rst_out", req_out[1], 64'd70);

    // Random traffic checked by the reference model.
    for (int c = 0; c < 1500; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (req_en[i]) begin
          if ($urandom_range(0, 1) == 1) req_en[i] = 1'b0;
        end else if (req_ready[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_in[i][0] = rnd_fe();
            req_in[i][1] = rnd_fe();
            req_en[i]    = 1'b1;
          end
        end else if ($urandom_range(0, 9) == 0) begin
          req_en[i] = 1'b1;
        end
      end
    end
    req_en = '0;
    wait_idle(100);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
